// File: rtl/operand_fetch.sv
// ID-stage operand fetch: drives register-file reads, bypasses same-cycle writeback,
// tracks in-flight writes per register and hands registered operands to EX.
module operand_fetch #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int PEND_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wr,
    input  logic [AW-1:0] id_rd,
    output logic [AW-1:0] rf_addr_A,
    output logic [AW-1:0] rf_addr_B,
    input  logic [DW-1:0] rf_data_A,
    input  logic [DW-1:0] rf_data_B,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          flush,
    output logic          op_valid,
    input  logic          ex_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          op_wr,
    output logic [AW-1:0] op_rd,
    output logic          sb_err
);
    localparam int NREG = 2 ** AW;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];
    logic              op_valid_q, op_valid_d;
    logic [DW-1:0]     op_a_q, op_a_d;
    logic [DW-1:0]     op_b_q, op_b_d;
    logic              op_wr_q, op_wr_d;
    logic [AW-1:0]     op_rd_q, op_rd_d;
    logic              sb_err_q, sb_err_d;

    logic              wb_nz, hit_rs, hit_rt, hit_rd;
    logic [PEND_W-1:0] eff_rs, eff_rt;
    logic              haz, accept;
    logic [DW-1:0]     sel_a, sel_b;

    assign rf_addr_A = id_rs;
    assign rf_addr_B = id_rt;

    // Writebacks to register 0 never count as hits.
    assign wb_nz  = wb_valid & (wb_addr != '0);
    assign hit_rs = wb_nz & (wb_addr == id_rs);
    assign hit_rt = wb_nz & (wb_addr == id_rt);
    assign hit_rd = wb_nz & (wb_addr == id_rd);
    assign eff_rs = pend_q[id_rs] - PEND_W'(hit_rs);
    assign eff_rt = pend_q[id_rt] - PEND_W'(hit_rt);

    assign haz = (id_use_rs & (id_rs != '0) & (eff_rs != '0))
               | (id_use_rt & (id_rt != '0) & (eff_rt != '0))
               | (id_wr & (id_rd != '0) & (pend_q[id_rd] == PEND_MAX) & !hit_rd);

    assign id_ready = !haz & (!op_valid_q | ex_ready) & !flush;
    assign accept   = id_valid & id_ready;

    assign sel_a = (id_rs == '0) ? '0 : (hit_rs ? wb_data : rf_data_A);
    assign sel_b = (id_rt == '0) ? '0 : (hit_rt ? wb_data : rf_data_B);

    always_comb begin
        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_wr_d    = op_wr_q;
        op_rd_d    = op_rd_q;
        if (flush) begin
            op_valid_d = 1'b0;
        end else if (accept) begin
            op_valid_d = 1'b1;
            op_a_d     = sel_a;
            op_b_d     = sel_b;
            op_wr_d    = id_wr;
            op_rd_d    = id_rd;
        end else if (ex_ready) begin
            op_valid_d = 1'b0;
        end
    end

    // Issue, retire and squash terms on the same register sum in one edge.
    always_comb begin
        for (int r = 0; r < NREG; r++) pend_d[r] = '0;
        sb_err_d = sb_err_q | (wb_nz & (pend_q[wb_addr] == '0));
        for (int r = 1; r < NREG; r++) begin
            pend_d[r] = pend_q[r]
                      + PEND_W'(accept & id_wr & (id_rd == AW'(r)))
                      - PEND_W'(wb_nz & (wb_addr == AW'(r)) & (pend_q[r] != '0))
                      - PEND_W'(flush & op_valid_q & op_wr_q & (op_rd_q == AW'(r)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_wr_q    <= 1'b0;
            op_rd_q    <= '0;
            sb_err_q   <= 1'b0;
            for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
        end else begin
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_wr_q    <= op_wr_d;
            op_rd_q    <= op_rd_d;
            sb_err_q   <= sb_err_d;
            for (int r = 0; r < NREG; r++) pend_q[r] <= pend_d[r];
        end
    end

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_wr    = op_wr_q;
    assign op_rd    = op_rd_q;
    assign sb_err   = sb_err_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: driver pushes hand-computed operands into a queue,
// an independent monitor pops and compares whenever EX consumes or a flush squashes.
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready, id_use_rs, id_use_rt, id_wr;
    logic [4:0]  id_rs, id_rt, id_rd, rf_addr_A, rf_addr_B, wb_addr, op_rd;
    logic [31:0] rf_data_A, rf_data_B, wb_data, op_a, op_b;
    logic        wb_valid, flush, op_valid, ex_ready, op_wr, sb_err;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        wr;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wr(id_wr), .id_rd(id_rd),
        .rf_addr_A(rf_addr_A), .rf_addr_B(rf_addr_B),
        .rf_data_A(rf_data_A), .rf_data_B(rf_data_B),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .op_valid(op_valid), .ex_ready(ex_ready),
        .op_a(op_a), .op_b(op_b), .op_wr(op_wr), .op_rd(op_rd), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: consumes one expected entry per EX handshake or squash.
    always @(negedge clk) begin
        if (rst && op_valid && (flush || ex_ready)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: op_a=0x%0h with no expected entry", op_a);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (!flush) begin
                    chk("op_a", 64'(op_a), 64'(e.a));
                    chk("op_b", 64'(op_b), 64'(e.b));
                    chk("op_wr", 64'(op_wr), 64'(e.wr));
                    chk("op_rd", 64'(op_rd), 64'(e.rd));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wr,
                         input logic [4:0] rd, input logic [31:0] da, input logic [31:0] db);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wr = wr; id_rd = rd; rf_data_A = da; rf_data_B = db;
    endtask

    task automatic setwb(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid = v; wb_addr = a; wb_data = d;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic wr,
                        input logic [4:0] rd);
        exp_t e;
        e.a = a; e.b = b; e.wr = wr; e.rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        setwb(1'b0, 5'd0, 32'h0);
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ex_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_op_valid", 64'(op_valid), 64'd0);
        chk("reset_op_a", 64'(op_a), 64'd0);
        chk("reset_sb_err", 64'(sb_err), 64'd0);
        chk("reset_pend3", 64'(dut.pend_q[3]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // add r3 <- r1, r2
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 32'd5, 32'd7);
        #1;
        chk("t1_ready", 64'(id_ready), 64'd1);
        chk("t1_addr_A", 64'(rf_addr_A), 64'd1);
        chk("t1_addr_B", 64'(rf_addr_B), 64'd2);
        push(32'd5, 32'd7, 1'b1, 5'd3);
        step();
        chk("t1_op_valid", 64'(op_valid), 64'd1);
        chk("t1_pend3", 64'(dut.pend_q[3]), 64'd1);

        // reader of r3 stalls until writeback, then takes the bypassed value
        drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h11, 32'h0);
        #1;
        chk("t2_stall0", 64'(id_ready), 64'd0);
        step();
        chk("t2_stall1", 64'(id_ready), 64'd0);
        step();
        chk("t2_stall2", 64'(id_ready), 64'd0);
        setwb(1'b1, 5'd3, 32'h2A);
        #1;
        chk("t2_wb_ready", 64'(id_ready), 64'd1);
        push(32'h2A, 32'h0, 1'b0, 5'd0);
        step();
        idle();
        #1;
        chk("t2_pend3", 64'(dut.pend_q[3]), 64'd0);

        // B-side bypass: writer to r4 then reader of rt=4
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0);
        push(32'h0, 32'h0, 1'b1, 5'd4);
        step();
        drive(1'b1, 5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 32'h66);
        #1;
        chk("t2b_stall", 64'(id_ready), 64'd0);
        step();
        setwb(1'b1, 5'd4, 32'h77);
        #1;
        chk("t2b_ready", 64'(id_ready), 64'd1);
        push(32'h55, 32'h77, 1'b0, 5'd0);
        step();
        idle();
        step();
        chk("t2b_pend4", 64'(dut.pend_q[4]), 64'd0);

        // EX backpressure holds the output stage
        ex_ready = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 32'h100, 32'h200);
        #1;
        chk("t3_first_ready", 64'(id_ready), 64'd1);
        push(32'h100, 32'h200, 1'b0, 5'd0);
        step();
        drive(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 32'h300, 32'h400);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_hold_ready", 64'(id_ready), 64'd0);
            chk("t3_hold_a", 64'(op_a), 64'h100);
            chk("t3_hold_b", 64'(op_b), 64'h200);
            step();
        end
        ex_ready = 1'b1;
        #1;
        chk("t3_release_ready", 64'(id_ready), 64'd1);
        push(32'h300, 32'h400, 1'b0, 5'd0);
        step();
        chk("t3_next_a", 64'(op_a), 64'h300);
        idle();
        step();

        // scoreboard saturation on r5
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_writer_ready", 64'(id_ready), 64'd1);
            push(32'h0, 32'h0, 1'b1, 5'd5);
            step();
        end
        chk("t4_pend5_full", 64'(dut.pend_q[5]), 64'd3);
        chk("t4_full_stall0", 64'(id_ready), 64'd0);
        step();
        chk("t4_full_stall1", 64'(id_ready), 64'd0);
        setwb(1'b1, 5'd5, 32'h1);
        #1;
        chk("t4_wb_ready", 64'(id_ready), 64'd1);
        push(32'h0, 32'h0, 1'b1, 5'd5);
        step();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("t4_pend5_same", 64'(dut.pend_q[5]), 64'd3);
        for (int i = 0; i < 3; i++) step();
        setwb(1'b0, 5'd0, 32'h0);
        #1;
        chk("t4_pend5_drained", 64'(dut.pend_q[5]), 64'd0);
        chk("t4_no_err", 64'(sb_err), 64'd0);

        // flush squashes a pending write to r9
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0, 32'h0);
        push(32'h0, 32'h0, 1'b1, 5'd9);
        step();
        chk("t5_pend9", 64'(dut.pend_q[9]), 64'd1);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        chk("t5_flush_ready", 64'(id_ready), 64'd0);
        step();
        idle();
        #1;
        chk("t5_op_valid", 64'(op_valid), 64'd0);
        chk("t5_pend9_cleared", 64'(dut.pend_q[9]), 64'd0);
        chk("t5_pend10", 64'(dut.pend_q[10]), 64'd0);

        // stray writeback and register 0 reads
        setwb(1'b1, 5'd7, 32'h99);
        step();
        setwb(1'b0, 5'd0, 32'h0);
        #1;
        chk("t6_sb_err_set", 64'(sb_err), 64'd1);
        chk("t6_pend7", 64'(dut.pend_q[7]), 64'd0);
        repeat (3) step();
        chk("t6_sb_err_sticky", 64'(sb_err), 64'd1);
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        setwb(1'b1, 5'd0, 32'hDEAD);
        #1;
        chk("t6_r0_ready", 64'(id_ready), 64'd1);
        push(32'h0, 32'h0, 1'b0, 5'd0);
        step();
        idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
